alu_exec_unit: RTL and testbench

Execution end of the ALU issue path. Consumes the 127-bit issue packet from the ALU reservation station, reads source operands from the physical register file, and executes the operation. It then broadcasts the result tag and data on the ALU result bus, which is the wakeup and PRF-write source for every reservation station, and reports completion to the ROB. The unit is a fixed two-stage pipeline (RR, EX) that never stalls, because the reservation station has no backpressure.

---
 rtl/alu_exec_unit_if.sv | 21 ++
 rtl/alu_exec_unit.sv | 121 ++++++++++++
 tb/tb_alu_exec_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// ALU result bus: tag/data broadcast for wakeup and PRF write, plus ROB completion.
interface alu_exec_unit_if #(
  parameter int XLEN = 32,
  parameter int TAGW = 8
);
  logic            ALU_result_valid;
  logic [TAGW-1:0] ALU_result_dest;
  logic [XLEN-1:0] ALU_result_data;
  logic            rob_done_valid;
  logic [31:0]     rob_done_inst_num;

  modport master (
    output ALU_result_valid, ALU_result_dest, ALU_result_data,
    output rob_done_valid, rob_done_inst_num
  );

  modport slave (
    input ALU_result_valid, ALU_result_dest, ALU_result_data,
    input rob_done_valid, rob_done_inst_num
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Two-stage (RR, EX) non-stalling ALU execution unit feeding the result bus and ROB.
// Define ALU_BYPASS_EN to forward the EX result into RR operands; otherwise the PRF must read write-first.
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int TAGW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [126:0]     issue_pkt,
  output logic [TAGW-1:0]  prf_raddr1,
  output logic [TAGW-1:0]  prf_raddr2,
  input  logic [XLEN-1:0]  prf_rdata1,
  input  logic [XLEN-1:0]  prf_rdata2,
  alu_exec_unit_if.master  res
);
  localparam int SHW = $clog2(XLEN);

  // RR stage registers
  logic            rr_valid_reg;
  logic [TAGW-1:0] rr_tag_reg [2];
  logic [31:0]     rr_inst_reg;
  logic [XLEN-1:0] rr_pc_reg;
  logic [TAGW-1:0] rr_rd_reg;
  logic [3:0]      rr_aluop_reg;
  logic            rr_src1_reg;
  logic            rr_src2_reg;
  logic [XLEN-1:0] rr_imm_reg;

  // EX stage registers
  logic            ex_valid_reg;
  logic [TAGW-1:0] ex_dest_reg;
  logic [XLEN-1:0] ex_data_reg;
  logic [31:0]     ex_inst_reg;

  logic [XLEN-1:0] rdata [2];
  logic [XLEN-1:0] opnd  [2];
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;

  assign prf_raddr1 = rr_tag_reg[0];
  assign prf_raddr2 = rr_tag_reg[1];
  assign rdata[0]   = prf_rdata1;
  assign rdata[1]   = prf_rdata2;

  // Tag 0 is the hardwired zero register regardless of what the PRF returns.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
`ifdef ALU_BYPASS_EN
      assign opnd[gi] = (rr_tag_reg[gi] == '0) ? '0 :
                        (ex_valid_reg && (ex_dest_reg == rr_tag_reg[gi])) ? ex_data_reg :
                        rdata[gi];
`else
      assign opnd[gi] = (rr_tag_reg[gi] == '0) ? '0 : rdata[gi];
`endif
    end
  endgenerate

  assign src_a = rr_src1_reg ? rr_pc_reg  : opnd[0];
  assign src_b = rr_src2_reg ? rr_imm_reg : opnd[1];

  always_comb begin
    alu_result = '0;
    case (rr_aluop_reg)
      4'd0:    alu_result = src_a + src_b;
      4'd1:    alu_result = src_a - src_b;
      4'd2:    alu_result = src_a << src_b[SHW-1:0];
      4'd3:    alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'd4:    alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      4'd5:    alu_result = src_a ^ src_b;
      4'd6:    alu_result = src_a >> src_b[SHW-1:0];
      4'd7:    alu_result = $unsigned($signed(src_a) >>> src_b[SHW-1:0]);
      4'd8:    alu_result = src_a | src_b;
      4'd9:    alu_result = src_a & src_b;
      4'd10:   alu_result = src_b;
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rr_valid_reg  <= 1'b0;
      rr_tag_reg[0] <= '0;
      rr_tag_reg[1] <= '0;
      rr_inst_reg   <= '0;
      rr_pc_reg     <= '0;
      rr_rd_reg     <= '0;
      rr_aluop_reg  <= '0;
      rr_src1_reg   <= 1'b0;
      rr_src2_reg   <= 1'b0;
      rr_imm_reg    <= '0;
      ex_valid_reg  <= 1'b0;
      ex_dest_reg   <= '0;
      ex_data_reg   <= '0;
      ex_inst_reg   <= '0;
    end else begin
      rr_valid_reg  <= issue_pkt[78];
      rr_tag_reg[1] <= issue_pkt[126:119];
      rr_tag_reg[0] <= issue_pkt[118:111];
      rr_inst_reg   <= issue_pkt[110:79];
      rr_pc_reg     <= issue_pkt[77:46];
      rr_rd_reg     <= issue_pkt[45:38];
      rr_aluop_reg  <= issue_pkt[37:34];
      rr_src1_reg   <= issue_pkt[33];
      rr_src2_reg   <= issue_pkt[32];
      rr_imm_reg    <= issue_pkt[31:0];
      ex_valid_reg  <= rr_valid_reg;
      ex_dest_reg   <= rr_rd_reg;
      // Writes to the zero register still broadcast, but carry zero data.
      ex_data_reg   <= (rr_rd_reg == '0) ? '0 : alu_result;
      ex_inst_reg   <= rr_inst_reg;
    end
  end

  assign res.ALU_result_valid  = ex_valid_reg;
  assign res.ALU_result_dest   = ex_dest_reg;
  assign res.ALU_result_data   = ex_data_reg;
  assign res.rob_done_valid    = ex_valid_reg;
  assign res.rob_done_inst_num = ex_inst_reg;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed packets push expectations, a monitor checks the result bus.
module tb_alu_exec_unit;
  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [126:0] issue_pkt;
  logic [7:0]   prf_raddr1, prf_raddr2;
  logic [31:0]  prf_rdata1, prf_rdata2;
  logic [31:0]  prf [256];
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;

  typedef struct {
    int          cyc;
    logic [7:0]  dest;
    logic [31:0] data;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  alu_exec_unit_if #(.XLEN(32), .TAGW(8)) bus ();

  alu_exec_unit #(.XLEN(32), .TAGW(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .issue_pkt(issue_pkt),
    .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2),
    .prf_rdata1(prf_rdata1), .prf_rdata2(prf_rdata2),
    .res(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PRF model: written at the end of the broadcast cycle; write-first reads when the unit has no bypass.
  always @(posedge clk)
    if (bus.ALU_result_valid && bus.ALU_result_dest != 8'd0)
      prf[bus.ALU_result_dest] <= bus.ALU_result_data;

  always_comb begin
    prf_rdata1 = prf[prf_raddr1];
    prf_rdata2 = prf[prf_raddr2];
`ifndef ALU_BYPASS_EN
    if (bus.ALU_result_valid && bus.ALU_result_dest == prf_raddr1 && prf_raddr1 != 8'd0)
      prf_rdata1 = bus.ALU_result_data;
    if (bus.ALU_result_valid && bus.ALU_result_dest == prf_raddr2 && prf_raddr2 != 8'd0)
      prf_rdata2 = bus.ALU_result_data;
`endif
  end

  function automatic logic [126:0] mk(input logic [7:0] t2, input logic [7:0] t1,
                                      input logic [31:0] inst, input logic v,
                                      input logic [31:0] pc, input logic [7:0] rd,
                                      input logic [3:0] op, input logic s1, input logic s2,
                                      input logic [31:0] imm);
    return {t2, t1, inst, v, pc, rd, op, s1, s2, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Present a packet for one cycle; when expected, its broadcast is due two cycles later.
  task automatic issue(input logic [126:0] pkt, input bit expect_out,
                       input logic [7:0] d, input logic [31:0] data);
    exp_t e;
    issue_pkt = pkt;
    if (expect_out) begin
      e.cyc  = cyc + 2;
      e.dest = d;
      e.data = data;
      e.inst = pkt[110:79];
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    issue_pkt = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.ALU_result_valid}, 32'd0);
    chk({tag, "_dest"},  {24'd0, bus.ALU_result_dest}, 32'd0);
    chk({tag, "_data"},  bus.ALU_result_data, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, bus.rob_done_valid}, 32'd0);
    chk({tag, "_rinst"}, bus.rob_done_inst_num, 32'd0);
  endtask

  always @(negedge clk) begin
    if (bus.ALU_result_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_broadcast actual=dest %h data %h required=none (cycle %0d)",
                 bus.ALU_result_dest, bus.ALU_result_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        $display("txn cycle=%0d dest=%h data=%h inst=%0d", cyc,
                 bus.ALU_result_dest, bus.ALU_result_data, bus.rob_done_inst_num);
        chk("latency", cyc, mon_e.cyc);
        chk("dest", {24'd0, bus.ALU_result_dest}, {24'd0, mon_e.dest});
        chk("data", bus.ALU_result_data, mon_e.data);
        chk("rob_inst", bus.rob_done_inst_num, mon_e.inst);
        chk("rob_valid", {31'd0, bus.rob_done_valid}, 32'd1);
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_broadcast actual=none required=dest %h data %h due cycle %0d",
               sb[0].dest, sb[0].data, sb[0].cyc);
      void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < 256; i++) prf[i] = 32'd0;
    prf[0] = 32'h0000_DEAD;
    prf[1] = 32'h8000_0000;
    prf[2] = 32'hFFFF_FFFF;
    prf[5] = 32'd3;
    prf[6] = 32'd4;
    reset = 1'b1;
    flush = 1'b0;
    issue_pkt = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic operations
    issue(mk(8'd6, 8'd5, 32'd7,  1, 32'h0,   8'd9,  4'd0, 0, 0, 32'h0),  1, 8'd9,  32'd7);
    idle(3);
    issue(mk(8'd0, 8'd0, 32'd8,  1, 32'h100, 8'd10, 4'd0, 1, 1, 32'h10), 1, 8'd10, 32'h110);
    issue(mk(8'd0, 8'd1, 32'd9,  1, 32'h0,   8'd11, 4'd7, 0, 1, 32'd4),  1, 8'd11, 32'hF800_0000);
    issue(mk(8'd0, 8'd2, 32'd10, 1, 32'h0,   8'd30, 4'd3, 0, 1, 32'd1),  1, 8'd30, 32'd1);
    issue(mk(8'd0, 8'd2, 32'd11, 1, 32'h0,   8'd31, 4'd4, 0, 1, 32'd1),  1, 8'd31, 32'd0);
    issue(mk(8'd6, 8'd5, 32'd12, 1, 32'h0,   8'd32, 4'd1, 0, 0, 32'h0),  1, 8'd32, 32'hFFFF_FFFF);
    issue(mk(8'd0, 8'd5, 32'd13, 1, 32'h0,   8'd33, 4'd2, 0, 1, 32'h21), 1, 8'd33, 32'd6);
    issue(mk(8'd6, 8'd5, 32'd14, 1, 32'h0,   8'd34, 4'd5, 0, 0, 32'h0),  1, 8'd34, 32'd7);
    issue(mk(8'd0, 8'd1, 32'd15, 1, 32'h0,   8'd35, 4'd6, 0, 1, 32'd4),  1, 8'd35, 32'h0800_0000);
    issue(mk(8'd6, 8'd5, 32'd16, 1, 32'h0,   8'd36, 4'd8, 0, 0, 32'h0),  1, 8'd36, 32'd7);
    issue(mk(8'd6, 8'd5, 32'd17, 1, 32'h0,   8'd37, 4'd9, 0, 0, 32'h0),  1, 8'd37, 32'd0);
    issue(mk(8'd0, 8'd0, 32'd18, 1, 32'h0,   8'd38, 4'd10, 0, 1, 32'h1234), 1, 8'd38, 32'h1234);
    issue(mk(8'd6, 8'd5, 32'd19, 1, 32'h0,   8'd39, 4'd11, 0, 0, 32'h0), 1, 8'd39, 32'd0);
    issue(mk(8'd6, 8'd5, 32'd20, 1, 32'h0,   8'd40, 4'd15, 0, 0, 32'h0), 1, 8'd40, 32'd0);
    idle(3);

    // Dependent ops one cycle apart: stale PRF for tag 12/13 must be covered
    issue(mk(8'd0,  8'd0,  32'd21, 1, 32'h0, 8'd12, 4'd10, 0, 1, 32'h55), 1, 8'd12, 32'h55);
    issue(mk(8'd0,  8'd12, 32'd22, 1, 32'h0, 8'd14, 4'd0,  0, 1, 32'd1),  1, 8'd14, 32'h56);
    issue(mk(8'd0,  8'd0,  32'd23, 1, 32'h0, 8'd13, 4'd10, 0, 1, 32'h21), 1, 8'd13, 32'h21);
    issue(mk(8'd13, 8'd13, 32'd24, 1, 32'h0, 8'd15, 4'd0,  0, 0, 32'h0),  1, 8'd15, 32'h42);
    idle(3);

    // Zero register source and destination
    issue(mk(8'd5, 8'd0, 32'd25, 1, 32'h0, 8'd3, 4'd8,  0, 0, 32'h0),  1, 8'd3, 32'd3);
    issue(mk(8'd0, 8'd0, 32'd26, 1, 32'h0, 8'd4, 4'd0,  0, 0, 32'h0),  1, 8'd4, 32'd0);
    issue(mk(8'd0, 8'd0, 32'd27, 1, 32'h0, 8'd0, 4'd10, 0, 1, 32'h77), 1, 8'd0, 32'd0);
    idle(3);

    // Flush kills both in-flight ops
    c0 = cyc;
    issue(mk(8'd0, 8'd0, 32'd28, 1, 32'h0, 8'd50, 4'd10, 0, 1, 32'h1), 0, 8'd0, 32'd0);
    flush = 1'b1;
    issue(mk(8'd0, 8'd0, 32'd29, 1, 32'h0, 8'd51, 4'd10, 0, 1, 32'h2), 0, 8'd0, 32'd0);
    flush = 1'b0;
    chk("flush_n2_cycle", cyc, c0 + 2);
    chk_zero("flush_n2");
    issue(mk(8'd0, 8'd0, 32'd30, 1, 32'h0, 8'd52, 4'd10, 0, 1, 32'h3), 1, 8'd52, 32'h3);
    chk_zero("flush_n3");
    idle(3);

    // Streaming back-to-back
    for (int i = 0; i < 8; i++)
      issue(mk(8'd0, 8'd0, 32'(100 + i), 1, 32'h0, 8'(20 + i), 4'd0, 0, 1, 32'(i * 3 + 1)),
            1, 8'(20 + i), 32'(i * 3 + 1));
    issue(mk(8'd0, 8'd0, 32'd200, 0, 32'h0, 8'd60, 4'd0, 0, 1, 32'h9), 0, 8'd0, 32'd0);
    idle(3);

    // Reset mid-stream
    issue(mk(8'd0, 8'd0, 32'd300, 1, 32'h0, 8'd61, 4'd10, 0, 1, 32'hA), 1, 8'd61, 32'hA);
    issue(mk(8'd0, 8'd0, 32'd301, 1, 32'h0, 8'd62, 4'd10, 0, 1, 32'hB), 0, 8'd0, 32'd0);
    reset = 1'b1;
    issue(mk(8'd0, 8'd0, 32'd302, 1, 32'h0, 8'd63, 4'd10, 0, 1, 32'hC), 0, 8'd0, 32'd0);
    chk_zero("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    idle(5);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
